// File: rtl/score_sched_pkg.sv
// Shared constants for the scoring scheduler: default weights and bias, FSM
// encoding and the jerk saturation helper.
package score_sched_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_SAT  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic signed [15:0] DEF_W_ACCEL = 16'sd2;
  localparam logic signed [15:0] DEF_W_JERK  = 16'sd3;
  localparam logic signed [15:0] DEF_W_STEER = 16'sd1;
  localparam logic signed [15:0] DEF_W_BRAKE = 16'sd4;
  localparam logic signed [15:0] DEF_BIAS    = 16'sd20;

  // Difference of two signed bytes, clamped back into -128..127.
  function automatic logic signed [7:0] jerk_sat(input logic signed [7:0] cur,
                                                 input logic signed [7:0] prev);
    logic signed [8:0] diff;
    diff = {cur[7], cur} - {prev[7], prev};
    if (diff > 9'sd127)       jerk_sat = 8'sd127;
    else if (diff < -9'sd128) jerk_sat = -8'sd128;
    else                      jerk_sat = diff[7:0];
  endfunction

endpackage

// File: rtl/score_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with
// wrap, wins; returns the one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_valid
);

  int c;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(ptr) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!grant_valid && req[c]) begin
        grant_valid = 1'b1;
        grant[c]    = 1'b1;
        grant_idx   = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/score_sched.sv
// Shares one sequential weighted MAC across NUM_CH sensor channels and hands
// each clamped 0..255 score downstream tagged with its channel id.
module score_sched
  import score_sched_pkg::*;
#(
  parameter int                 NUM_CH  = 4,
  parameter int                 CH_W    = $clog2(NUM_CH),
  parameter logic signed [15:0] W_ACCEL = DEF_W_ACCEL,
  parameter logic signed [15:0] W_JERK  = DEF_W_JERK,
  parameter logic signed [15:0] W_STEER = DEF_W_STEER,
  parameter logic signed [15:0] W_BRAKE = DEF_W_BRAKE,
  parameter logic signed [15:0] BIAS    = DEF_BIAS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   req_valid,
  output logic [NUM_CH-1:0]   req_ready,
  input  logic [8*NUM_CH-1:0] accel_in,
  input  logic [8*NUM_CH-1:0] steer_in,
  input  logic [8*NUM_CH-1:0] brake_in,
  output logic                score_valid,
  input  logic                score_ready,
  output logic [7:0]          score,
  output logic [CH_W-1:0]     score_ch,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_ready only in IDLE, score_valid only in OUT, data held until taken.

  logic [1:0]         state_q, state_d;
  logic [1:0]         term_q, term_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic signed [7:0]  accel_q, accel_d;
  logic signed [7:0]  jerk_q, jerk_d;
  logic signed [7:0]  steer_q, steer_d;
  logic [7:0]         brake_q, brake_d;
  logic signed [15:0] acc_q, acc_d;
  logic [7:0]         score_q, score_d;
  logic [CH_W-1:0]    score_ch_q, score_ch_d;
  logic signed [7:0]  prev_accel_q [NUM_CH];
  logic signed [7:0]  prev_accel_d [NUM_CH];
  logic [NUM_CH-1:0]  seen_q, seen_d;

  logic [NUM_CH-1:0]  gnt;
  logic [CH_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic signed [7:0]  sel_accel, sel_steer;
  logic [7:0]         sel_brake;
  logic signed [15:0] term_ext, term_w, mac_prod;

  rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
    .req         (req_valid),
    .ptr         (ptr_q),
    .grant       (gnt),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  assign sel_accel = accel_in[{gnt_idx, 3'b000} +: 8];
  assign sel_steer = steer_in[{gnt_idx, 3'b000} +: 8];
  assign sel_brake = brake_in[{gnt_idx, 3'b000} +: 8];

  // Term order: accel, jerk, steer, brake; brake is an unsigned magnitude.
  always_comb begin
    term_ext = '0;
    term_w   = '0;
    case (term_q)
      2'd0: begin term_ext = {{8{accel_q[7]}}, accel_q}; term_w = W_ACCEL; end
      2'd1: begin term_ext = {{8{jerk_q[7]}}, jerk_q};   term_w = W_JERK;  end
      2'd2: begin term_ext = {{8{steer_q[7]}}, steer_q}; term_w = W_STEER; end
      default: begin term_ext = {8'b0, brake_q};         term_w = W_BRAKE; end
    endcase
    mac_prod = term_ext * term_w;
  end

  always_comb begin
    state_d      = state_q;
    term_d       = term_q;
    ptr_d        = ptr_q;
    ch_d         = ch_q;
    accel_d      = accel_q;
    jerk_d       = jerk_q;
    steer_d      = steer_q;
    brake_d      = brake_q;
    acc_d        = acc_q;
    score_d      = score_q;
    score_ch_d   = score_ch_q;
    prev_accel_d = prev_accel_q;
    seen_d       = seen_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          accel_d = sel_accel;
          steer_d = sel_steer;
          brake_d = sel_brake;
          jerk_d  = seen_q[gnt_idx] ? jerk_sat(sel_accel, prev_accel_q[gnt_idx]) : 8'sd0;
          ch_d    = gnt_idx;
          acc_d   = BIAS;
          term_d  = 2'd0;
          ptr_d   = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
          prev_accel_d[gnt_idx] = sel_accel;
          seen_d[gnt_idx]       = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        acc_d  = acc_q + mac_prod;
        term_d = term_q + 2'd1;
        if (term_q == 2'd3) state_d = ST_SAT;
      end
      ST_SAT: begin
        if (acc_q[15])                score_d = 8'd0;
        else if (acc_q > 16'sd255)    score_d = 8'd255;
        else                          score_d = acc_q[7:0];
        score_ch_d = ch_q;
        state_d    = ST_OUT;
      end
      ST_OUT: begin
        if (score_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      term_q     <= '0;
      ptr_q      <= '0;
      ch_q       <= '0;
      accel_q    <= '0;
      jerk_q     <= '0;
      steer_q    <= '0;
      brake_q    <= '0;
      acc_q      <= '0;
      score_q    <= '0;
      score_ch_q <= '0;
      seen_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) prev_accel_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      term_q       <= term_d;
      ptr_q        <= ptr_d;
      ch_q         <= ch_d;
      accel_q      <= accel_d;
      jerk_q       <= jerk_d;
      steer_q      <= steer_d;
      brake_q      <= brake_d;
      acc_q        <= acc_d;
      score_q      <= score_d;
      score_ch_q   <= score_ch_d;
      seen_q       <= seen_d;
      prev_accel_q <= prev_accel_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE) ? gnt : '0;
  assign score_valid = (state_q == ST_OUT);
  assign score       = score_q;
  assign score_ch    = score_ch_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_score_sched.sv
// Directed bench for score_sched: latency, scores, clamping, round-robin order,
// backpressure hold and reset mid-operation, all against hand-computed values.
module tb_score_sched;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                clk;
  logic                rst;
  logic [NUM_CH-1:0]   req_valid;
  logic [NUM_CH-1:0]   req_ready;
  logic [8*NUM_CH-1:0] accel_in;
  logic [8*NUM_CH-1:0] steer_in;
  logic [8*NUM_CH-1:0] brake_in;
  logic                score_valid;
  logic                score_ready;
  logic [7:0]          score;
  logic [CH_W-1:0]     score_ch;
  logic                busy;
  logic [1:0]          state_dbg;

  int checks = 0;
  int errors = 0;

  score_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .accel_in    (accel_in),
    .steer_in    (steer_in),
    .brake_in    (brake_in),
    .score_valid (score_valid),
    .score_ready (score_ready),
    .score       (score),
    .score_ch    (score_ch),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_ch(input int c, input logic [7:0] a, input logic [7:0] s,
                        input logic [7:0] b);
    accel_in[8*c +: 8] = a;
    steer_in[8*c +: 8] = s;
    brake_in[8*c +: 8] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One isolated sample on channel c; checks grant, latency, score and channel.
  task automatic do_sample(input string tag, input int c, input logic [7:0] a,
                           input logic [7:0] s, input logic [7:0] b,
                           input logic [7:0] exp_score);
    int n;
    @(negedge clk);
    set_ch(c, a, s, b);
    req_valid = NUM_CH'(1) << c;
    #1;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(NUM_CH'(1) << c));
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_ready_mac"}, 32'(req_ready), 32'd0);
        req_valid = '0;
      end
    end while (!score_valid && n < 30);
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_score"}, 32'(score), 32'(exp_score));
    chk({tag, "_score_ch"}, 32'(score_ch), c);
    score_ready = 1'b1;
    @(negedge clk);
    score_ready = 1'b0;
    #1;
    chk({tag, "_done_valid"}, 32'(score_valid), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit saw_valid;
    rst         = 1'b0;
    req_valid   = '0;
    accel_in    = '0;
    steer_in    = '0;
    brake_in    = '0;
    score_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_score_valid", 32'(score_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_score_ch", 32'(score_ch), 32'd0);
    rst = 1'b1;

    // Single-channel scores, including jerk and both clamp directions
    do_sample("ch0_first", 0, 8'd10, 8'd5, 8'd3, 8'd57);
    do_sample("ch0_second", 0, 8'd20, 8'd5, 8'd3, 8'd107);
    do_sample("ch1_clamp_hi", 1, 8'd0, 8'd0, 8'd255, 8'd255);
    do_sample("ch2_clamp_lo", 2, 8'h80, 8'h80, 8'd0, 8'd0);

    // Round-robin with all channels requesting and downstream always ready
    do_reset();
    accel_in    = '0;
    steer_in    = '0;
    brake_in    = '0;
    req_valid   = '1;
    score_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n = 0;
      while (req_ready == '0 && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(NUM_CH'(1) << (k % NUM_CH)));
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (!score_valid && n < 20);
      chk("rr_score_ch", 32'(score_ch), k % NUM_CH);
      chk("rr_score", 32'(score), 32'd20);
    end
    req_valid   = '0;
    score_ready = 1'b0;

    // Backpressure: score held, no new grant while OUT waits
    do_reset();
    set_ch(3, 8'd1, 8'd2, 8'd0);
    req_valid = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0010;
    n = 1;
    while (!score_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp_latency", n, 6);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 32'(score_valid), 32'd1);
      chk("bp_score", 32'(score), 32'd24);
      chk("bp_score_ch", 32'(score_ch), 32'd3);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
    end
    score_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_next_grant", 32'(req_ready), 32'b0010);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    n = 1;
    while (!score_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp_ch1_score", 32'(score), 32'd20);
    chk("bp_ch1_score_ch", 32'(score_ch), 32'd1);
    @(negedge clk);
    score_ready = 1'b0;

    // Reset in the middle of MAC discards the sample and the channel history
    @(negedge clk);
    set_ch(0, 8'd50, 8'd0, 8'd0);
    req_valid = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(score_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (score_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_valid", 32'(saw_valid), 32'd0);
    do_sample("midrst_ch0", 0, 8'd10, 8'd5, 8'd3, 8'd57);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard cap so a stuck design still reaches the summary line
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
